paritysel_arbiter: RTL and testbench
====================================

# paritysel_arbiter

- Two-source, work-conserving round-robin arbiter that shares one output stream between requester A and requester B.
- The datapath is a `Param_paritysel_mux` instance. Its `sel` comes from a 5-bit slot counter whose LSB is overridden by the grant, so even parity selects A and odd parity selects B.
- The selected word is captured in a single registered output stage with a valid/ready handshake.
- Per-source saturating grant counters are provided for debug and statistics.

## Interface
- `WIDTH`, 8: data width of both inputs and the output.
- `CNT_W`, 16: width of each grant counter.
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: active-low reset, synchronous to `clk`.
- `a_valid`, in, 1: source A offers `a_data`.
- `a_data`, in, `WIDTH`: source A payload.
- `a_ready`, out, 1: source A transfer accepted this cycle.
- `b_valid`, in, 1: source B offers `b_data`.
- `b_data`, in, `WIDTH`: source B payload.
- `b_ready`, out, 1: source B transfer accepted this cycle.
- `out_valid`, out, 1: the output register holds a word.
- `out_data`, out, `WIDTH`: the registered word.
- `out_src`, out, 1: source of the registered word, 0 = A, 1 = B.
- `out_ready`, in, 1: the consumer accepts the word.
- `slot`, out, 5: current slot counter value.
- `cnt_clr`, in, 1: synchronously clears both grant counters.
- `cnt_a`, out, `CNT_W`: number of A grants, saturating.
- `cnt_b`, out, `CNT_W`: number of B grants, saturating.

## Operation
**Preference.** `slot[0]` sets the preferred source: 0 prefers A, 1 prefers B.

**Grant** (combinational):
- Grant the preferred source if its valid is high.
- Otherwise grant the other source if its valid is high.
- Otherwise grant nothing.

**Handshake.**
- `can_load = !out_valid || out_ready`.
- `a_ready = rst_n && can_load && grant==A`, and likewise for `b_ready`.
- At most one ready is high per cycle.
- Ready is never high without the matching valid.

**Mux drive.** Mux `sel = {slot[4:1], grant_is_b}`, `data_a = a_data`, `data_b = b_data`. The mux output feeds the `out_data` register.

**Output stage FSM.** Two states, EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- EMPTY → FULL when a transfer is accepted.
- FULL → FULL when `out_ready` and a new transfer are both accepted in the same cycle (pass-through, no bubble).
- FULL → EMPTY when `out_ready` is high and no source is granted.
- FULL holds `out_data`/`out_src` stable while `out_ready` is low.

**Slot counter.**
- Increments by 1 on every accepted transfer, regardless of which source was granted.
- Wraps 31→0.
- Unchanged when no transfer occurs.

**Grant counters.**
- `cnt_a` increments on each A transfer; `cnt_b` on each B transfer.
- Each saturates at 2^`CNT_W`−1.
- `cnt_clr` has priority over increment in the same cycle.

**Reset.**
- While `rst_n` is low, on each `clk` edge: `out_valid=0`, `out_data=0`, `out_src=0`, `slot=0`, `cnt_a=0`, `cnt_b=0`.
- `a_ready` and `b_ready` are forced 0 combinationally.
- A word held mid-handshake is dropped. The consumer must not count it as delivered.

## Timing
- Latency from input acceptance to `out_valid`: 1 cycle.
- Sustained throughput: 1 word/cycle while `out_ready` stays high.
- Both sources continuously valid: grants alternate A, B, A, B starting from `slot=0`.
- One source idle: the other receives every cycle, and the slot still advances.
- `out_ready` low in FULL: both readies are 0, and the slot and counters are frozen.
- Simultaneous valid rise on both sources after reset: A wins, because `slot=0`.
- Slot wrap 31→0: the preference returns to A. Parity alternation stays continuous because 31 is odd and 0 is even.

## Structure
- Package `paritysel_pkg`:
  - `typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e`.
  - `typedef enum logic {ST_EMPTY, ST_FULL} ost_e`.
  - `localparam SLOT_W = 5`.
- One sub-module: `Param_paritysel_mux`, instantiated with `WIDTH` as the datapath.
- Grant logic, FSM and counters are kept in `paritysel_arbiter`.

## Test plan
1. **Reset.** Hold `rst_n=0` for 3 cycles with both valids high → `a_ready=b_ready=0`, `out_valid=0`, `slot=0`, `cnt_a=cnt_b=0`.
2. **Alternation.** Both valid continuously, `a_data=8'hA0+n`, `b_data=8'hB0+n`, `out_ready=1` for 8 cycles → `out_src` = 0,1,0,1,0,1,0,1; `slot=8`; `cnt_a=4`, `cnt_b=4`.
3. **Work conserving.** Only B valid for 5 cycles, `out_ready=1` → 5 B words with no bubbles, `slot=5`, `cnt_b=5`.
4. **Backpressure.** FULL holding `8'h5A`, `out_ready=0` for 4 cycles with both valids high → `out_data` stays `8'h5A`, both readies 0, slot unchanged. On `out_ready=1`, the next word loads in the same cycle.
5. **Wrap and saturation.** Run 33 transfers with `CNT_W=2` and A only → `slot` wraps to 1, `cnt_a` saturates at 3. With `cnt_clr` and a transfer in the same cycle → `cnt_a=0`.
6. **Mid-operation reset.** Assert `rst_n=0` while FULL with `out_ready=0` → next edge gives `out_valid=0` and `slot=0`. After release, both valid → A is granted first.

Source files
------------

// File: rtl/paritysel_pkg.sv
// Shared types and constants for the parity-select round-robin arbiter.
package paritysel_pkg;

  localparam int SLOT_W = 5;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} ost_e;

  // Builds the mux select: upper slot bits pass through, the LSB is
  // replaced by the grant so its parity picks the source.
  function automatic logic [SLOT_W-1:0] slot_sel(input logic [SLOT_W-1:0] slot_v,
                                                 input logic              grant_is_b);
    return {slot_v[SLOT_W-1:1], grant_is_b};
  endfunction

endpackage

// File: rtl/Param_paritysel_mux.sv
// Two-input datapath mux steered by the parity (LSB) of the select word:
// even selects data_a, odd selects data_b.
module Param_paritysel_mux #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_o
);

  // Upper select bits carry slot history only; they do not steer the data.
  logic unused_sel_s;
  assign unused_sel_s = ^sel[SEL_W-1:1];

  // Parity-steered selection between the two payloads.
  always_comb begin
    if (sel[0]) begin
      data_o = data_b;
    end else begin
      data_o = data_a;
    end
  end

endmodule

// File: rtl/paritysel_arbiter.sv
// Two-source work-conserving round-robin arbiter with a single registered
// output stage, a 5-bit slot counter steering preference, and saturating
// per-source grant counters.
module paritysel_arbiter
  import paritysel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [WIDTH-1:0]  a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [WIDTH-1:0]  b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [SLOT_W-1:0] slot,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ost_e              state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  src_e              src_q, src_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;

  logic              grant_valid_s;
  src_e              grant_src_s;
  logic              can_load_s;
  logic              xfer_s;
  logic              a_xfer_s;
  logic              b_xfer_s;
  logic [SLOT_W-1:0] mux_sel_s;
  logic [WIDTH-1:0]  mux_data_s;

  // Round-robin grant: slot parity names the preferred source, the other
  // source is served whenever the preferred one is idle.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_A;
    if (slot_q[0] == 1'b0) begin
      if (a_valid) begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_A;
      end else if (b_valid) begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_B;
      end else begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_A;
      end
    end else begin
      if (b_valid) begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_B;
      end else if (a_valid) begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_A;
      end else begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_A;
      end
    end
  end

  // Readies are gated by reset so nothing is accepted while it is held.
  assign can_load_s = (state_q == ST_EMPTY) || out_ready;
  assign xfer_s     = rst_n && can_load_s && grant_valid_s;
  assign a_xfer_s   = xfer_s && (grant_src_s == SRC_A);
  assign b_xfer_s   = xfer_s && (grant_src_s == SRC_B);
  assign a_ready    = a_xfer_s;
  assign b_ready    = b_xfer_s;

  assign mux_sel_s = slot_sel(slot_q, grant_src_s == SRC_B);

  Param_paritysel_mux #(
    .WIDTH (WIDTH),
    .SEL_W (SLOT_W)
  ) u_mux (
    .sel    (mux_sel_s),
    .data_a (a_data),
    .data_b (b_data),
    .data_o (mux_data_s)
  );

  // Output stage next state: load on transfer, drain when consumed and idle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_d = ST_FULL;
          data_d  = mux_data_s;
          src_d   = grant_src_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_s) begin
          state_d = ST_FULL;
          data_d  = mux_data_s;
          src_d   = grant_src_s;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Slot advances once per accepted word; counters saturate, clear wins.
  always_comb begin
    slot_d  = slot_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (xfer_s) begin
      slot_d = slot_q + SLOT_W'(1);
    end else begin
      slot_d = slot_q;
    end
    if (cnt_clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (a_xfer_s && (cnt_a_q != CNT_MAX)) begin
        cnt_a_d = cnt_a_q + CNT_W'(1);
      end else begin
        cnt_a_d = cnt_a_q;
      end
      if (b_xfer_s && (cnt_b_q != CNT_MAX)) begin
        cnt_b_d = cnt_b_q + CNT_W'(1);
      end else begin
        cnt_b_d = cnt_b_q;
      end
    end
  end

  // Output stage FSM and its registered word/source; reset drops any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= SRC_A;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  // Slot counter and grant statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      slot_q  <= slot_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign slot      = slot_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_paritysel_arbiter.sv
// Directed table-driven bench for paritysel_arbiter. A second instance with
// 2-bit counters shares the stimulus to observe counter saturation.
module tb_paritysel_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready, cnt_clr;
  logic [7:0] a_data, b_data;

  logic        a_ready, b_ready, out_valid, out_src;
  logic [7:0]  out_data;
  logic [4:0]  slot;
  logic [15:0] cnt_a, cnt_b;

  logic        s_a_ready, s_b_ready, s_out_valid, s_out_src;
  logic [7:0]  s_out_data;
  logic [4:0]  s_slot;
  logic [1:0]  s_cnt_a, s_cnt_b;

  int errors = 0;
  int checks = 0;

  paritysel_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .slot(slot), .cnt_clr(cnt_clr),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  paritysel_arbiter #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
    .out_ready(out_ready), .slot(s_slot), .cnt_clr(cnt_clr),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn, av, bv, ordy, clr;
    logic [7:0]  ad, bd;
    logic        ar, br, ov, os;
    logic [7:0]  od;
    logic [4:0]  sl;
    logic [15:0] ca, cb;
    logic        chk_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rstn, input logic av, input logic [7:0] ad,
                              input logic bv, input logic [7:0] bd, input logic ordy,
                              input logic clr, input logic ar, input logic br,
                              input logic ov, input logic os, input logic [7:0] od,
                              input logic [4:0] sl, input logic [15:0] ca,
                              input logic [15:0] cb, input logic chk_cnt);
    vec_t v;
    v.rstn = rstn; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.clr = clr; v.ar = ar; v.br = br; v.ov = ov; v.os = os; v.od = od;
    v.sl = sl; v.ca = ca; v.cb = cb; v.chk_cnt = chk_cnt;
    return v;
  endfunction

  // Drive one cycle: readies checked mid-cycle, registers after the edge.
  task automatic apply(input string tag, input vec_t v);
    rst_n = v.rstn; a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd;
    out_ready = v.ordy; cnt_clr = v.clr;
    @(negedge clk);
    chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, v.ar});
    chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, v.br});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.ov});
    chk({tag, ".out_src"}, {31'd0, out_src}, {31'd0, v.os});
    chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, v.od});
    chk({tag, ".slot"}, {27'd0, slot}, {27'd0, v.sl});
    if (v.chk_cnt) begin
      chk({tag, ".cnt_a"}, {16'd0, cnt_a}, {16'd0, v.ca});
      chk({tag, ".cnt_b"}, {16'd0, cnt_b}, {16'd0, v.cb});
    end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    out_ready = 1'b0; cnt_clr = 1'b0;

    // Reset: 3 cycles with both valids high.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0, 16'd0, 1'b1));
    // Alternation: A on even slots, B on odd slots.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] nn;
      logic       odd;
      nn  = n[7:0];
      odd = nn[0];
      tbl.push_back(mk(1'b1, 1'b1, 8'hA0 + nn, 1'b1, 8'hB0 + nn, 1'b1, 1'b0,
                       !odd, odd, 1'b1, odd, odd ? 8'hB0 + nn : 8'hA0 + nn,
                       5'(n + 1), 16'((n + 2) / 2), 16'((n + 1) / 2), 1'b1));
    end
    // Drain while clearing counters.
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'hB7, 5'd8, 16'd0, 16'd0, 1'b1));
    // Work conserving: B only, served every cycle even on A-preferred slots.
    for (int n = 0; n < 5; n++)
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hC0 + 8'(n), 1'b1, 1'b0,
                       1'b0, 1'b1, 1'b1, 1'b1, 8'hC0 + 8'(n), 5'(9 + n),
                       16'd0, 16'(n + 1), 1'b1));
    // Backpressure: load 5A, hold 4 cycles, then pass-through load.
    tbl.push_back(mk(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd14, 16'd1, 16'd5, 1'b1));
    for (int n = 0; n < 4; n++)
      tbl.push_back(mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 5'd14, 16'd1, 16'd5, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 5'd15, 16'd2, 16'd5, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 5'd16, 16'd2, 16'd6, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 5'd16, 16'd2, 16'd6, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 5'd16, 16'd2, 16'd6, 1'b1));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

    // Wrap and saturation: fresh reset, 31 A-only transfers to slot 31.
    apply("wrap.rst", mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0, 16'd0, 1'b1));
    for (int i = 0; i < 31; i++)
      apply($sformatf("wrapA%0d", i), mk(1'b1, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b0,
                       1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 5'(i + 1), 16'(i + 1), 16'd0, 1'b1));
    chk("sat.mid.cnt_a", {30'd0, s_cnt_a}, 32'd3);
    // Slot 31 prefers B, then wrap to 0 prefers A again.
    apply("wrap31", mk(1'b1, 1'b1, 8'hE1, 1'b1, 8'hE2, 1'b1, 1'b0,
                       1'b0, 1'b1, 1'b1, 1'b1, 8'hE2, 5'd0, 16'd31, 16'd1, 1'b1));
    apply("wrap0", mk(1'b1, 1'b1, 8'hE3, 1'b1, 8'hE4, 1'b1, 1'b0,
                      1'b1, 1'b0, 1'b1, 1'b0, 8'hE3, 5'd1, 16'd32, 16'd1, 1'b1));
    chk("sat.cnt_a", {30'd0, s_cnt_a}, 32'd3);
    chk("sat.cnt_b", {30'd0, s_cnt_b}, 32'd1);
    chk("sat.slot", {27'd0, s_slot}, 32'd1);
    // Clear wins over a same-cycle A transfer.
    apply("clr", mk(1'b1, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 5'd2, 16'd0, 16'd0, 1'b1));
    chk("clr.s_cnt_a", {30'd0, s_cnt_a}, 32'd0);

    // Mid-operation reset while FULL and stalled.
    apply("mid.load", mk(1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0,
                         1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 5'd3, 16'd1, 16'd0, 1'b1));
    apply("mid.rst0", mk(1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0, 16'd0, 1'b1));
    apply("mid.rst1", mk(1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0, 16'd0, 1'b1));
    apply("mid.rel", mk(1'b1, 1'b1, 8'h81, 1'b1, 8'h82, 1'b1, 1'b0,
                        1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 5'd1, 16'd1, 16'd0, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
